// File: rtl/uart_serial_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_serial_port_pkg
// Description : Shared definitions for the 8N1 UART. The TX and RX state
//               encodings and the data width of one frame.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_serial_port_pkg;

    // Both FSMs use the same four-state sequence.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int c_frame_bits = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered storage. pop_data is the
//               head entry and is stable while the FIFO is not empty.
//               Storage resets to zero so pop_data reads 0 out of reset.
// Ports       : clk, reset (sync, active-high), push/push_data, pop/pop_data,
//               full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push on full is accepted
    // when it coincides with a pop.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_serial_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_serial_port
// Description : 8N1 UART. TX serialises handshaked bytes onto serial_out;
//               RX synchronises serial_in, samples mid-bit and queues bytes
//               in a sync_fifo. Sticky overrun / framing error flags.
// Ports       : clk, reset (sync, active-high)
//               serial_in / serial_out        - line side, idle high
//               tx_data, tx_valid, tx_ready    - TX byte handshake
//               rx_data, rx_valid, rx_ready    - RX FIFO head / pop
//               rx_overrun, rx_frame_err       - sticky error flags
//               err_clr                        - clears both flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_serial_port
    import uart_serial_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int RX_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic       serial_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       err_clr
);

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_ready_pt  = c_cnt_w'(CLKS_PER_BIT - 2);
    localparam logic [2:0]         c_last_bit  = 3'(c_frame_bits - 1);

    // ------------------------------------------------------------------ TX
    uart_state_t        r_tx_state;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_tx_shift;
    logic               r_serial_out;
    logic               r_tx_ready;
    logic               w_tx_accept;

    assign serial_out  = r_serial_out;
    assign tx_ready    = r_tx_ready;
    assign w_tx_accept = tx_valid && r_tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state   <= ST_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_serial_out <= 1'b1;
            r_tx_ready   <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_accept) begin
                        r_tx_shift   <= tx_data;
                        r_serial_out <= 1'b0;
                        r_tx_ready   <= 1'b0;
                        r_tx_cnt     <= '0;
                        r_tx_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt     <= '0;
                        r_tx_bit     <= '0;
                        r_serial_out <= r_tx_shift[0];
                        r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state   <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == c_last_bit) begin
                            r_serial_out <= 1'b1;
                            r_tx_state   <= ST_STOP;
                        end else begin
                            r_tx_bit     <= r_tx_bit + 3'd1;
                            r_serial_out <= r_tx_shift[0];
                            r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                    end
                end
                ST_STOP: begin
                    // Ready is raised one cycle early so a new byte can be
                    // accepted in the last stop cycle, giving gapless frames.
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt <= '0;
                        if (w_tx_accept) begin
                            r_tx_shift   <= tx_data;
                            r_serial_out <= 1'b0;
                            r_tx_ready   <= 1'b0;
                            r_tx_state   <= ST_START;
                        end else begin
                            r_tx_state <= ST_IDLE;
                        end
                    end else begin
                        if (r_tx_cnt == c_ready_pt) begin
                            r_tx_ready <= 1'b1;
                        end
                        r_tx_cnt <= r_tx_cnt + c_cnt_w'(1);
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_prev;
    uart_state_t        r_rx_state;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               r_rx_wait_high;
    logic               w_stop_sample;
    logic               w_push;
    logic               w_frame_evt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_overrun_evt;
    logic [$clog2(RX_DEPTH):0] w_rx_count_unused;
    logic               r_overrun;
    logic               r_frame_err;

    assign w_stop_sample = (r_rx_state == ST_STOP) && !r_rx_wait_high
                           && (r_rx_cnt == c_bit_last);
    assign w_push        = w_stop_sample && r_sync2;
    assign w_frame_evt   = w_stop_sample && !r_sync2;
    assign w_pop         = rx_ready && !w_empty;
    assign w_overrun_evt = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_rx_prev      <= 1'b1;
            r_rx_state     <= ST_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_wait_high <= 1'b0;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_sync2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: a high line means the edge was a glitch.
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit == c_last_bit) begin
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                ST_STOP: begin
                    // After a bad stop bit, hold here until the line idles so
                    // a low line is not mistaken for a new start bit.
                    if (r_rx_wait_high) begin
                        if (r_sync2) begin
                            r_rx_wait_high <= 1'b0;
                            r_rx_state     <= ST_IDLE;
                        end
                    end else if (r_rx_cnt == c_bit_last) begin
                        r_rx_cnt <= '0;
                        if (r_sync2) begin
                            r_rx_state <= ST_IDLE;
                        end else begin
                            r_rx_wait_high <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_overrun_evt || (r_overrun && !err_clr);
            r_frame_err <= w_frame_evt || (r_frame_err && !err_clr);
        end
    end

    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;
    assign rx_valid     = !w_empty;

    sync_fifo #(
        .WIDTH (c_frame_bits),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_rx_shift),
        .pop       (w_pop),
        .pop_data  (rx_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_rx_count_unused)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_serial_port
// Description : Directed self-checking bench for uart_serial_port with
//               CLKS_PER_BIT=4 and RX_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_serial_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       serial_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       err_clr;

    logic line;
    logic loop_en;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    assign serial_in = loop_en ? serial_out : line;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_serial_port #(
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .err_clr      (err_clr)
    );

    // Drive one frame on the RX line, starting and ending on a negedge.
    // Returns on the negedge of the stop-sample cycle; optionally pops then.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_end);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (CPB) @(negedge clk);
        end
        line = stop;
        repeat (CPB) @(negedge clk);
        if (pop_at_end) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    // Offer a byte and wait (bounded) for acceptance; returns on the negedge
    // after the accept edge with tx_valid dropped.
    task automatic tx_send(input logic [7:0] d, output int acc_cyc);
        logic got;
        got      = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            if (tx_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL tx_accept_timeout got tx_ready=%b exp 1", tx_ready);
        end
        acc_cyc = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial_out got %b exp 1", serial_out); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", rx_overrun); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", rx_frame_err); end
    endtask

    task automatic test_tx();
        logic [9:0] exp_bits;
        int         t;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        tx_send(8'hA5, t);
        // Now at cycle t+1: start bit should be on the line.
        for (int k = 0; k < 10 * CPB; k++) begin
            checks++;
            if (serial_out !== exp_bits[k / CPB]) begin
                errors++;
                $display("FAIL tx_bit cycle t+%0d got %b exp %b", k + 1, serial_out, exp_bits[k / CPB]);
            end
            if (k == 10 * CPB - 2) begin
                checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_t39 got %b exp 0", tx_ready); end
            end
            if (k == 10 * CPB - 1) begin
                checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_t40 got %b exp 1", tx_ready); end
            end
            @(negedge clk);
        end
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL tx_idle_after got %b exp 1", serial_out); end
    endtask

    task automatic test_rx();
        send_frame(8'h3C, 1'b1, 1'b0);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_valid_at_sample got %b exp 0", rx_valid); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_valid_latency got %b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rx_data_3c got %h exp 3c", rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop_empty got %b exp 0", rx_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            send_frame(vals[i], 1'b1, 1'b0);
            repeat (2) @(negedge clk);
            if (i == 3) begin
                checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL overrun_at_full got %b exp 0", rx_overrun); end
            end
        end
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", rx_overrun); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b exp 0", rx_overrun); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_%0d got %b exp 1", i, rx_valid); end
            checks++; if (rx_data !== vals[i]) begin errors++; $display("FAIL ovr_data_%0d got %h exp %h", i, rx_data, vals[i]); end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b exp 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hFF, 1'b0, 1'b0);
        line = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set got %b exp 1", rx_frame_err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_nopush got %b exp 0", rx_valid); end
        // Receiver must be back in service after the line idles.
        send_frame(8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin errors++; $display("FAIL frame_err_recover got %h/%b exp 5a/1", rx_data, rx_valid); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clr got %b exp 0", rx_frame_err); end
        // Two-cycle low glitch.
        line = 1'b0;
        repeat (2) @(negedge clk);
        line = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_push got %b exp 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL glitch_flag got %b exp 0", rx_frame_err); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] vals [5];
        vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            send_frame(vals[i], 1'b1, 1'b0);
            repeat (2) @(negedge clk);
        end
        // Fifth frame with a pop in exactly the push cycle.
        send_frame(vals[4], 1'b1, 1'b1);
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL pushpop_overrun got %b exp 0", rx_overrun); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL pushpop_valid_%0d got %b exp 1", i, rx_valid); end
            checks++; if (rx_data !== vals[i]) begin errors++; $display("FAIL pushpop_data_%0d got %h exp %h", i, rx_data, vals[i]); end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL pushpop_count got %b exp 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        loop_en = 1'b1;
        tx_send(8'h00, a0);
        tx_send(8'hFF, a1);
        checks++; if (a1 - a0 != 10 * CPB) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", a1 - a0, 10 * CPB); end
        repeat (60) @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin errors++; $display("FAIL loop_first got %h/%b exp 00/1", rx_data, rx_valid); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin errors++; $display("FAIL loop_second got %h/%b exp ff/1", rx_data, rx_valid); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL loop_drained got %b exp 0", rx_valid); end
        // Reset in the middle of a frame.
        tx_send(8'h55, a2);
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL midframe_start got %b exp 0", serial_out); end
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL midframe_reset_line got %b exp 1", serial_out); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midframe_reset_ready got %b exp 1", tx_ready); end
        reset = 1'b0;
        loop_en = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midframe_reset_rx got %b exp 0", rx_valid); end
    endtask

    initial begin
        reset    = 1'b1;
        line     = 1'b1;
        loop_en  = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_tx();
        test_rx();
        test_overrun();
        test_frame_err();
        test_full_push_pop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
